// File: rtl/battle_sprite_anim.sv
// Battle sprite renderer: multi-frame, scaled, optionally mirrored sprite with a
// transparency key and a slide-in entry animation. Drives an external sprite ROM
// (palette indices) and palette ROM (12-bit RGB). Pixel latency is ROM_LAT+4.
// Optional feature macro: BATTLE_SPRITE_FLASH_EN adds flash_in and a damage flash
// (opaque pixels forced white during frame ticks 4-7 of every 8).
module battle_sprite_anim #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 144,
  parameter int FRAMES     = 2,
  parameter int SCALE_LOG2 = 0,
  parameter int ROM_LAT    = 1,
  parameter int TRANSP_IDX = 0,
  parameter int SLIDE_DIST = 320,
  parameter int SLIDE_STEP = 8,
  localparam int FSEL_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int ADDR_W    = $clog2(FRAMES * WIDTH * HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [FSEL_W-1:0] frame_sel_in,
  input  logic              flip_in,
  input  logic              start_in,
  input  logic              hide_in,
`ifdef BATTLE_SPRITE_FLASH_EN
  input  logic              flash_in,
`endif
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [7:0]        rom_data_in,
  output logic [7:0]        pal_addr_out,
  input  logic [11:0]       pal_data_in,
  output logic [11:0]       pixel_out,
  output logic              opaque_out,
  output logic              busy_out,
  output logic              done_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLIDE = 2'd1,
    ST_SHOWN = 2'd2
  } state_e;

  localparam logic [11:0] DIST_C   = 12'(SLIDE_DIST);
  localparam logic [11:0] STEP_C   = 12'(SLIDE_STEP);
  localparam logic [11:0] SPAN_W_C = 12'(WIDTH << SCALE_LOG2);
  localparam logic [11:0] SPAN_H_C = 12'(HEIGHT << SCALE_LOG2);
  localparam logic [11:0] COL_MAX  = 12'(WIDTH - 1);
  localparam logic [7:0]  TRANSP_C = 8'(TRANSP_IDX);

  state_e              state_q, state_d;
  logic [11:0]         offset_q, offset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FSEL_W-1:0]   frame_q, frame_d;
  logic                flip_q, flip_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]    vld_q, vld_d;
  logic [7:0]          pal_addr_q, pal_addr_d;
  logic                opq1_q, opq1_d;
  logic                opq2_q, opq2_d;
  logic [11:0]         pixel_q, pixel_d;
  logic                opaque_q, opaque_d;

  logic                tick_s;
  logic [11:0]         step_s;
  logic [11:0]         xe_s, ye_s, hc_s, vc_s;
  logic [11:0]         dx_s, dy_s, col_raw_s, col_s, row_s;
  logic                region_s;
  logic [ADDR_W-1:0]   addr_calc_s;

`ifdef BATTLE_SPRITE_FLASH_EN
  logic [2:0]          tick_cnt_q, tick_cnt_d;
`endif

  // Frame tick: first pixel of every video frame.
  always_comb begin
    tick_s = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  end

  // Slide-in state machine next-state; start beats hide, hide beats the slide.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    done_d   = 1'b0;
    step_s   = (offset_q < STEP_C) ? offset_q : STEP_C;
    if (start_in) begin
      state_d  = ST_SLIDE;
      offset_d = DIST_C;
    end else if (hide_in) begin
      state_d  = ST_IDLE;
      offset_d = 12'd0;
    end else begin
      case (state_q)
        ST_SLIDE: begin
          if (tick_s) begin
            offset_d = offset_q - step_s;
            if (offset_q == step_s) begin
              state_d = ST_SHOWN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_SLIDE;
            end
          end else begin
            offset_d = offset_q;
          end
        end
        ST_IDLE, ST_SHOWN: begin
          state_d = state_q;
        end
        default: begin
          state_d  = ST_IDLE;
          offset_d = 12'd0;
        end
      endcase
    end
    busy_d = (state_d == ST_SLIDE);
  end

  // Frame select and mirror only change at the frame tick so a frame never tears.
  always_comb begin
    if (tick_s) begin
      frame_d = frame_sel_in;
      flip_d  = flip_in;
    end else begin
      frame_d = frame_q;
      flip_d  = flip_q;
    end
  end

  // Address stage: region test in 12 bits and sprite ROM address generation.
  always_comb begin
    xe_s      = {1'b0, x_in} + offset_q;
    ye_s      = {2'b00, y_in};
    hc_s      = {1'b0, hcount_in};
    vc_s      = {2'b00, vcount_in};
    region_s  = (state_q != ST_IDLE) &&
                (hc_s >= xe_s) && (hc_s < xe_s + SPAN_W_C) &&
                (vc_s >= ye_s) && (vc_s < ye_s + SPAN_H_C);
    dx_s      = hc_s - xe_s;
    dy_s      = vc_s - ye_s;
    col_raw_s = dx_s >> SCALE_LOG2;
    row_s     = dy_s >> SCALE_LOG2;
    if (flip_q) begin
      col_s = COL_MAX - col_raw_s;
    end else begin
      col_s = col_raw_s;
    end
    addr_calc_s = ADDR_W'(frame_q) * ADDR_W'(WIDTH * HEIGHT) +
                  ADDR_W'(row_s) * ADDR_W'(WIDTH) + ADDR_W'(col_s);
    if (region_s) begin
      rom_addr_d = addr_calc_s;
    end else begin
      rom_addr_d = {ADDR_W{1'b0}};
    end
  end

  // Data stages: in-region flag travels with the data; transparency keyed on the index.
  always_comb begin
    vld_d      = {vld_q[ROM_LAT-1:0], region_s};
    pal_addr_d = rom_data_in;
    opq1_d     = vld_q[ROM_LAT] && (rom_data_in != TRANSP_C);
    opq2_d     = opq1_q;
    if (opq2_q) begin
      opaque_d = 1'b1;
`ifdef BATTLE_SPRITE_FLASH_EN
      if (flash_in && tick_cnt_q[2]) begin
        pixel_d = 12'hFFF;
      end else begin
        pixel_d = pal_data_in;
      end
`else
      pixel_d = pal_data_in;
`endif
    end else begin
      opaque_d = 1'b0;
      pixel_d  = 12'h000;
    end
  end

`ifdef BATTLE_SPRITE_FLASH_EN
  // Damage-flash phase counter, advanced once per video frame.
  always_comb begin
    if (tick_s) begin
      tick_cnt_d = tick_cnt_q + 3'd1;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Damage-flash phase counter register.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      tick_cnt_q <= 3'd0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end
`endif

  // Slide-in state machine registers with registered status outputs.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      offset_q <= 12'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      frame_q  <= {FSEL_W{1'b0}};
      flip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      frame_q  <= frame_d;
      flip_q   <= flip_d;
    end
  end

  // Pixel pipeline registers.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      rom_addr_q <= {ADDR_W{1'b0}};
      vld_q      <= {(ROM_LAT + 1){1'b0}};
      pal_addr_q <= 8'd0;
      opq1_q     <= 1'b0;
      opq2_q     <= 1'b0;
      pixel_q    <= 12'h000;
      opaque_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      vld_q      <= vld_d;
      pal_addr_q <= pal_addr_d;
      opq1_q     <= opq1_d;
      opq2_q     <= opq2_d;
      pixel_q    <= pixel_d;
      opaque_q   <= opaque_d;
    end
  end

  assign rom_addr_out = rom_addr_q;
  assign pal_addr_out = pal_addr_q;
  assign pixel_out    = pixel_q;
  assign opaque_out   = opaque_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_battle_sprite_anim.sv
// Bench for battle_sprite_anim: two instances (scale 1x / ROM latency 1, and
// scale 2x / ROM latency 2) share all inputs; each drives its own ROM models.
module tb_battle_sprite_anim;
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 144;
  localparam int LAT0   = 5;
  localparam int LAT1   = 6;
  localparam int EXP_TICKS = (320 + 8 - 1) / 8;

  logic clk = 1'b0;
  logic rst;
  logic [10:0] x_in, hcount;
  logic [9:0]  y_in, vcount;
  logic fsel, flip, start, hide;
`ifdef BATTLE_SPRITE_FLASH_EN
  logic flash_s;
`endif
  logic [15:0] rom_addr0, rom_addr1;
  logic [7:0]  rom_data0, rom_data1, rp1a, pal_addr0, pal_addr1;
  logic [11:0] pal_data0, pal_data1, pixel0, pixel1;
  logic opaque0, opaque1, busy0, busy1, done0, done1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_mode, m_off, m_frame, m_flip, m_cnt;
  bit m_busy, m_done;
  int exp_addr0[64], exp_addr1[64];
  bit exp_opq0[64], exp_opq1[64], exp_flash[64];
  logic [11:0] exp_col0[64], exp_col1[64];
  int cur_addr0, cur_addr1;
  bit cur_opq0, cur_opq1;
  logic [11:0] cur_pix0, cur_pix1;

  always #5 clk = ~clk;

  battle_sprite_anim #(.SCALE_LOG2(0), .ROM_LAT(1)) dut0 (
    .pixel_clk_in(clk), .rst_in(rst), .x_in(x_in), .y_in(y_in),
    .hcount_in(hcount), .vcount_in(vcount), .frame_sel_in(fsel), .flip_in(flip),
    .start_in(start), .hide_in(hide),
`ifdef BATTLE_SPRITE_FLASH_EN
    .flash_in(flash_s),
`endif
    .rom_addr_out(rom_addr0), .rom_data_in(rom_data0), .pal_addr_out(pal_addr0),
    .pal_data_in(pal_data0), .pixel_out(pixel0), .opaque_out(opaque0),
    .busy_out(busy0), .done_out(done0));

  battle_sprite_anim #(.SCALE_LOG2(1), .ROM_LAT(2)) dut1 (
    .pixel_clk_in(clk), .rst_in(rst), .x_in(x_in), .y_in(y_in),
    .hcount_in(hcount), .vcount_in(vcount), .frame_sel_in(fsel), .flip_in(flip),
    .start_in(start), .hide_in(hide),
`ifdef BATTLE_SPRITE_FLASH_EN
    .flash_in(flash_s),
`endif
    .rom_addr_out(rom_addr1), .rom_data_in(rom_data1), .pal_addr_out(pal_addr1),
    .pal_data_in(pal_data1), .pixel_out(pixel1), .opaque_out(opaque1),
    .busy_out(busy1), .done_out(done1));

  // Sprite ROM contents: address 160 holds index 5; others hashed, some transparent (0).
  function automatic logic [7:0] rom_f(input int a);
    int h;
    if (a == 160) return 8'd5;
    h = (a * 13 + a / 7) % 9;
    if (h == 0) return 8'd0;
    return 8'(h * 29);
  endfunction

  function automatic logic [11:0] pal_f(input logic [7:0] i);
    if (i == 8'd5) return 12'hABC;
    return 12'(int'(i) * 57 + 1);
  endfunction

  // External ROM models: sprite ROM latency 1 (dut0) / 2 (dut1), palette latency 1.
  always @(posedge clk) begin
    rom_data0 <= rom_f(int'(rom_addr0));
    rp1a      <= rom_f(int'(rom_addr1));
    rom_data1 <= rp1a;
    pal_data0 <= pal_f(pal_addr0);
    pal_data1 <= pal_f(pal_addr1);
  end

  // Reference: which source pixel a screen position shows, from the sprite geometry.
  function automatic void model_pix(input int hc, input int vc, input int s,
                                    output bit r, output int a);
    int xe, col, row;
    xe = int'(x_in) + m_off;
    r = (m_mode != 0) && (hc >= xe) && (hc < xe + (WIDTH << s)) &&
        (vc >= int'(y_in)) && (vc < int'(y_in) + (HEIGHT << s));
    a = 0;
    if (r) begin
      col = (hc - xe) >> s;
      if (m_flip != 0) col = WIDTH - 1 - col;
      row = (vc - int'(y_in)) >> s;
      a = m_frame * WIDTH * HEIGHT + row * WIDTH + col;
    end
  endfunction

  task automatic model_clear();
    m_mode = 0; m_off = 0; m_frame = 0; m_flip = 0; m_cnt = 0;
    m_busy = 0; m_done = 0;
    for (int i = 0; i < 64; i++) begin
      exp_addr0[i] = 0; exp_addr1[i] = 0; exp_opq0[i] = 0; exp_opq1[i] = 0;
      exp_flash[i] = 0; exp_col0[i] = 12'h000; exp_col1[i] = 12'h000;
    end
    cur_addr0 = 0; cur_addr1 = 0; cur_opq0 = 0; cur_opq1 = 0;
    cur_pix0 = 12'h000; cur_pix1 = 12'h000;
  endtask

  // One pixel clock: drive inputs, record what the outputs must show later, advance.
  task automatic drive_cycle(input int hc, input int vc, input bit st, input bit hd);
    bit r0, r1, tick;
    int a0, a1, stp, i;
    hcount = 11'(hc); vcount = 10'(vc); start = st; hide = hd;
    tick = (hc == 0) && (vc == 0);
    model_pix(hc, vc, 0, r0, a0);
    model_pix(hc, vc, 1, r1, a1);
    exp_addr0[(cyc + 1) % 64] = a0;
    exp_addr1[(cyc + 1) % 64] = a1;
    exp_opq0[(cyc + LAT0) % 64] = r0 && (rom_f(a0) != 8'd0);
    exp_col0[(cyc + LAT0) % 64] = pal_f(rom_f(a0));
    exp_opq1[(cyc + LAT1) % 64] = r1 && (rom_f(a1) != 8'd0);
    exp_col1[(cyc + LAT1) % 64] = pal_f(rom_f(a1));
    exp_flash[(cyc + 1) % 64] = 1'b0;
`ifdef BATTLE_SPRITE_FLASH_EN
    exp_flash[(cyc + 1) % 64] = flash_s && ((m_cnt % 8) >= 4);
`endif
    m_done = 0;
    if (st) begin
      m_mode = 1; m_off = 320;
    end else if (hd) begin
      m_mode = 0;
    end else if (m_mode == 1 && tick) begin
      stp = (m_off < 8) ? m_off : 8;
      m_off = m_off - stp;
      if (m_off == 0) begin m_mode = 2; m_done = 1; end
    end
    if (tick) begin m_frame = int'(fsel); m_flip = int'(flip); m_cnt++; end
    m_busy = (m_mode == 1);
    @(posedge clk); #1;
    cyc++;
    i = cyc % 64;
    cur_addr0 = exp_addr0[i]; cur_addr1 = exp_addr1[i];
    cur_opq0 = exp_opq0[i]; cur_opq1 = exp_opq1[i];
    cur_pix0 = cur_opq0 ? (exp_flash[i] ? 12'hFFF : exp_col0[i]) : 12'h000;
    cur_pix1 = cur_opq1 ? (exp_flash[i] ? 12'hFFF : exp_col1[i]) : 12'h000;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; hide = 1'b0; hcount = 11'd5; vcount = 10'd5;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pixel0, opaque0, busy0, done0, pixel1, opaque1, busy1, done1} !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs got pix0=%h opq0=%b busy0=%b done0=%b pix1=%h opq1=%b required all 0",
               pixel0, opaque0, busy0, done0, pixel1, opaque1);
    end
    checks++;
    if ({rom_addr0, rom_addr1, pal_addr0, pal_addr1} !== 48'd0) begin
      failures++;
      $display("FAIL reset_addr got rom0=%0d rom1=%0d pal0=%0d pal1=%0d required 0",
               rom_addr0, rom_addr1, pal_addr0, pal_addr1);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_sweep();
    for (int k = 0; k < 150; k++) begin
      drive_cycle(int'($urandom_range(1, 799)), int'($urandom_range(0, 524)), 1'b0, 1'b0);
      checks++;
      if ({pixel0, opaque0, pixel1, opaque1, busy0, busy1} !== 30'd0) begin
        failures++;
        $display("FAIL idle_sweep cyc=%0d got pix0=%h opq0=%b pix1=%h opq1=%b busy=%b required 0",
                 cyc, pixel0, opaque0, pixel1, opaque1, busy0);
      end
    end
  endtask

  task automatic test_slide();
    int ticks, done_at, ndone;
    x_in = 11'd10; y_in = 10'd20; fsel = 1'b0; flip = 1'b0;
    ticks = 0; done_at = -1; ndone = 0;
    drive_cycle(3, 3, 1'b1, 1'b0);
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL slide_start got busy0=%b busy1=%b required 1", busy0, busy1);
    end
    for (int f = 0; f < 45; f++) begin
      drive_cycle(0, 0, 1'b0, 1'b0);
      ticks++;
      if (done0 === 1'b1) begin ndone++; done_at = ticks; end
      checks++;
      if (busy0 !== m_busy || done0 !== m_done || busy1 !== m_busy || done1 !== m_done) begin
        failures++;
        $display("FAIL slide_tick tick=%0d got busy=%b done=%b required busy=%b done=%b",
                 ticks, busy0, done0, m_busy, m_done);
      end
      for (int k = 0; k < 3; k++) begin
        drive_cycle(int'($urandom_range(1, 700)), int'($urandom_range(0, 300)), 1'b0, 1'b0);
        checks++;
        if ({pixel0, opaque0, pixel1, opaque1} !== {cur_pix0, cur_opq0, cur_pix1, cur_opq1} ||
            rom_addr0 !== 16'(cur_addr0) || rom_addr1 !== 16'(cur_addr1) ||
            busy0 !== m_busy || done0 !== 1'b0) begin
          failures++;
          $display("FAIL slide_stream cyc=%0d got pix0=%h opq0=%b pix1=%h opq1=%b a0=%0d a1=%0d busy=%b required pix0=%h opq0=%b pix1=%h opq1=%b a0=%0d a1=%0d busy=%b",
                   cyc, pixel0, opaque0, pixel1, opaque1, rom_addr0, rom_addr1, busy0,
                   cur_pix0, cur_opq0, cur_pix1, cur_opq1, cur_addr0, cur_addr1, m_busy);
        end
      end
    end
    checks++;
    if (ndone != 1 || done_at != EXP_TICKS || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL slide_done got pulses=%0d at_tick=%0d busy=%b required pulses=1 at_tick=%0d busy=0",
               ndone, done_at, busy0, EXP_TICKS);
    end
  endtask

  task automatic test_addr();
    x_in = 11'd10; y_in = 10'd20; fsel = 1'b0; flip = 1'b0;
    drive_cycle(0, 0, 1'b0, 1'b0);
    drive_cycle(10, 21, 1'b0, 1'b0);
    checks++;
    if (rom_addr0 !== 16'd160) begin
      failures++;
      $display("FAIL addr_160 got %0d required 160", rom_addr0);
    end
    repeat (3) drive_cycle(0, 21, 1'b0, 1'b0);
    checks++;
    if (pixel0 !== 12'h000 || opaque0 !== 1'b0) begin
      failures++;
      $display("FAIL addr_early got pix=%h opq=%b required 000/0 one cycle before latency", pixel0, opaque0);
    end
    drive_cycle(0, 21, 1'b0, 1'b0);
    checks++;
    if (pixel0 !== 12'hABC || opaque0 !== 1'b1) begin
      failures++;
      $display("FAIL addr_pixel got pix=%h opq=%b required ABC/1", pixel0, opaque0);
    end
  endtask

  task automatic test_flip();
    x_in = 11'd10; y_in = 10'd20; fsel = 1'b1; flip = 1'b1;
    drive_cycle(0, 0, 1'b0, 1'b0);
    drive_cycle(10, 20, 1'b0, 1'b0);
    checks++;
    if (rom_addr1 !== 16'd23199 || rom_addr0 !== 16'd23199) begin
      failures++;
      $display("FAIL flip_col159 got s1=%0d s0=%0d required 23199/23199", rom_addr1, rom_addr0);
    end
    drive_cycle(13, 20, 1'b0, 1'b0);
    checks++;
    if (rom_addr1 !== 16'd23198 || rom_addr0 !== 16'd23196) begin
      failures++;
      $display("FAIL flip_col158 got s1=%0d s0=%0d required 23198/23196", rom_addr1, rom_addr0);
    end
    for (int k = 0; k < 8; k++) begin
      drive_cycle(14 + k, 20 + k, 1'b0, 1'b0);
      checks++;
      if ({pixel0, opaque0, pixel1, opaque1} !== {cur_pix0, cur_opq0, cur_pix1, cur_opq1}) begin
        failures++;
        $display("FAIL flip_stream cyc=%0d got pix0=%h opq0=%b pix1=%h opq1=%b required pix0=%h opq0=%b pix1=%h opq1=%b",
                 cyc, pixel0, opaque0, pixel1, opaque1, cur_pix0, cur_opq0, cur_pix1, cur_opq1);
      end
    end
  endtask

  task automatic test_transp();
    x_in = 11'd10; y_in = 10'd20; fsel = 1'b0; flip = 1'b0;
    drive_cycle(0, 0, 1'b0, 1'b0);
    drive_cycle(10, 20, 1'b0, 1'b0);
    drive_cycle(11, 20, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_cycle(0, 20, 1'b0, 1'b0);
    checks++;
    if (pixel0 !== 12'h000 || opaque0 !== 1'b0) begin
      failures++;
      $display("FAIL transp_key got pix=%h opq=%b required 000/0", pixel0, opaque0);
    end
    drive_cycle(0, 20, 1'b0, 1'b0);
    checks++;
    if (pixel0 !== pal_f(rom_f(1)) || opaque0 !== 1'b1) begin
      failures++;
      $display("FAIL transp_neighbour got pix=%h opq=%b required %h/1", pixel0, opaque0, pal_f(rom_f(1)));
    end
    drive_cycle(0, 20, 1'b0, 1'b0);
    checks++;
    if (pixel1 !== 12'h000 || opaque1 !== 1'b0) begin
      failures++;
      $display("FAIL transp_scaled got pix=%h opq=%b required 000/0", pixel1, opaque1);
    end
  endtask

  task automatic test_hide_start();
    drive_cycle(7, 7, 1'b1, 1'b1);
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL start_beats_hide got busy0=%b busy1=%b required 1", busy0, busy1);
    end
    drive_cycle(10, 20, 1'b0, 1'b1);
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL hide_idle got busy=%b required 0", busy0);
    end
    for (int k = 0; k < 8; k++) begin
      drive_cycle(10 + k, 20 + k, 1'b0, 1'b0);
      checks++;
      if ({pixel0, opaque0, pixel1, opaque1} !== 26'd0 || rom_addr0 !== 16'd0) begin
        failures++;
        $display("FAIL hide_blank cyc=%0d got pix0=%h opq0=%b pix1=%h opq1=%b a0=%0d required 0",
                 cyc, pixel0, opaque0, pixel1, opaque1, rom_addr0);
      end
    end
  endtask

  task automatic test_random();
    int hc, vc;
    bit st, hd;
    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        x_in = 11'($urandom_range(0, 500)); y_in = 10'($urandom_range(0, 300));
        fsel = 1'($urandom); flip = 1'($urandom);
      end
`ifdef BATTLE_SPRITE_FLASH_EN
      if ($urandom_range(0, 49) == 0) flash_s = 1'($urandom);
`endif
      st = ($urandom_range(0, 199) == 0) || (m_mode == 0 && $urandom_range(0, 19) == 0);
      hd = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 4) == 0) begin
        hc = 0; vc = 0;
      end else begin
        hc = int'(x_in) + m_off + int'($urandom_range(0, 340)) - 6;
        vc = int'(y_in) + int'($urandom_range(0, 300)) - 6;
        if (hc < 1) hc = 1;
        if (vc < 0) vc = 0;
      end
      drive_cycle(hc, vc, st, hd);
      checks++;
      if ({pixel0, opaque0, pixel1, opaque1} !== {cur_pix0, cur_opq0, cur_pix1, cur_opq1} ||
          rom_addr0 !== 16'(cur_addr0) || rom_addr1 !== 16'(cur_addr1) ||
          busy0 !== m_busy || done0 !== m_done || busy1 !== m_busy || done1 !== m_done) begin
        failures++;
        $display("FAIL random_stream cyc=%0d got pix0=%h opq0=%b pix1=%h opq1=%b a0=%0d a1=%0d busy=%b done=%b required pix0=%h opq0=%b pix1=%h opq1=%b a0=%0d a1=%0d busy=%b done=%b",
                 cyc, pixel0, opaque0, pixel1, opaque1, rom_addr0, rom_addr1, busy0, done0,
                 cur_pix0, cur_opq0, cur_pix1, cur_opq1, cur_addr0, cur_addr1, m_busy, m_done);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive_cycle(3, 3, 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) begin
      drive_cycle(0, 0, 1'b0, 1'b0);
      drive_cycle(50, 50, 1'b0, 1'b0);
    end
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got busy=%b required 1", busy0);
    end
    do_reset();
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL midreset got busy0=%b busy1=%b done0=%b done1=%b required 0", busy0, busy1, done0, done1);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_cycle(0, 0, 1'b0, 1'b0);
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || opaque0 !== 1'b0) begin
        failures++;
        $display("FAIL midreset_idle got busy=%b done=%b opq=%b required 0", busy0, done0, opaque0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; x_in = 11'd10; y_in = 10'd20; hcount = 11'd5; vcount = 10'd5;
    fsel = 1'b0; flip = 1'b0; start = 1'b0; hide = 1'b0;
`ifdef BATTLE_SPRITE_FLASH_EN
    flash_s = 1'b0;
`endif
    model_clear();
    test_reset();
    test_idle_sweep();
    test_slide();
    test_addr();
    test_flip();
    test_transp();
    test_hide_start();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
